// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//   Drives the single address port of an async-read instruction memory.
//   This block owns the PC and registers each fetched word into the IF stage.
//   It handles pipeline stall and branch redirect. It also shares the memory
//   port with a program loader. When a load session ends, execution restarts
//   from RESET_PC.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             hold PC and IF outputs
//   branch_taken      one-cycle redirect pulse, target in branch_target
//   ld_req/addr/data  loader write request (one word per cycle while high)
//   ld_ack            write accepted this cycle
//   ld_count          words written in the current/last load session
//   mem_addr/we/wdata memory port (combinational from state)
//   mem_rdata         async read data
//   if_instr/pc/valid registered IF stage output
//   loading           high in LOAD and RESTART
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ack,
    output logic [ADDR_WIDTH:0]   ld_count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  if_valid,
    output logic                  loading
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RESTART = 2'd2
    } state_e;

    // Session word count saturates at the memory depth (2**ADDR_WIDTH).
    localparam logic [ADDR_WIDTH:0]   CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] if_instr_q;
    logic [ADDR_WIDTH-1:0] if_pc_q;
    logic                  if_valid_q;
    logic [ADDR_WIDTH:0]   ld_count_q;

    // Memory port. An asserted reset forces state_q to RUN at once, so a
    // write that is in flight is dropped without extra gating.
    always_comb begin
        mem_addr = pc_q;
        mem_we   = 1'b0;
        ld_ack   = 1'b0;
        if (state_q == ST_LOAD) begin
            mem_addr = ld_addr;
            mem_we   = ld_req;
            ld_ack   = ld_req;
        end
    end

    // Write data is passed straight through. Only mem_we qualifies it.
    assign mem_wdata = ld_data;
    assign loading   = (state_q != ST_RUN);

    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;
    assign ld_count  = ld_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            ld_count_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ld_req) begin
                        // Hand the port to the loader. No write on this edge,
                        // and the PC is left alone; RESTART reloads it.
                        state_q    <= ST_LOAD;
                        if_valid_q <= 1'b0;
                        ld_count_q <= '0;
                    end else if (branch_taken) begin
                        // Drop the word read from the old path this cycle.
                        pc_q       <= branch_target;
                        if_valid_q <= 1'b0;
                    end else if (!stall) begin
                        if_instr_q <= mem_rdata;
                        if_pc_q    <= pc_q;
                        if_valid_q <= 1'b1;
                        pc_q       <= pc_q + PC_ONE;  // wraps modulo depth
                    end
                end
                ST_LOAD: begin
                    if_valid_q <= 1'b0;
                    if (ld_req) begin
                        if (ld_count_q != CNT_MAX)
                            ld_count_q <= ld_count_q + CNT_ONE;
                    end else begin
                        state_q <= ST_RESTART;
                    end
                end
                ST_RESTART: begin
                    // Single cycle. ld_req is ignored here.
                    pc_q       <= RESET_PC;
                    if_valid_q <= 1'b0;
                    state_q    <= ST_RUN;
                end
                default: begin
                    state_q    <= ST_RUN;
                    pc_q       <= RESET_PC;
                    if_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, ld_req;
    logic [5:0]  branch_target, ld_addr;
    logic [31:0] ld_data;
    logic        ld_ack, mem_we, if_valid, loading;
    logic [6:0]  ld_count;
    logic [5:0]  mem_addr, if_pc;
    logic [31:0] mem_wdata, mem_rdata, if_instr;

    logic [31:0] ram [0:63];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .RESET_PC(6'd0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_ack(ld_ack), .ld_count(ld_count),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .loading(loading)
    );

    // Memory model: asynchronous read, synchronous write.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    typedef struct {
        logic        st, br;
        logic [5:0]  tgt;
        logic        lr;
        logic [5:0]  la;
        logic [31:0] ld;
        // expected before the edge
        logic [5:0]  e_ma;
        logic        e_we, e_ack, e_lo;
        // expected after the edge
        logic        e_v;
        logic [5:0]  e_pc;
        logic [31:0] e_in;
        logic [6:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic av(input logic st, br, input logic [5:0] tgt, input logic lr,
                      input logic [5:0] la, input logic [31:0] ld,
                      input logic [5:0] ma, input logic we, ack, lo,
                      input logic v, input logic [5:0] pc, input logic [31:0] in,
                      input logic [6:0] cnt);
        vec_t r;
        r.st = st; r.br = br; r.tgt = tgt; r.lr = lr; r.la = la; r.ld = ld;
        r.e_ma = ma; r.e_we = we; r.e_ack = ack; r.e_lo = lo;
        r.e_v = v; r.e_pc = pc; r.e_in = in; r.e_cnt = cnt;
        vq.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + i;
        rst_n = 1'b0; stall = 0; branch_taken = 0; branch_target = 0;
        ld_req = 0; ld_addr = 0; ld_data = 0;

        // Straight-line fetch from reset
        for (int i = 0; i < 5; i++)
            av(0,0,0, 0,0,0, 6'(i),0,0,0, 1,6'(i),32'h1000_0000+i,0);
        // Stall three cycles at pc=5
        for (int i = 0; i < 3; i++)
            av(1,0,0, 0,0,0, 6'd5,0,0,0, 1,6'd4,32'h1000_0004,0);
        av(0,0,0, 0,0,0, 6'd5,0,0,0, 1,6'd5,32'h1000_0005,0);
        av(0,0,0, 0,0,0, 6'd6,0,0,0, 1,6'd6,32'h1000_0006,0);
        // Branch at pc=7 to 0x20, then again with stall asserted
        av(0,1,6'h20, 0,0,0, 6'd7,0,0,0,   0,6'd6, 32'h1000_0006,0);
        av(0,0,0,     0,0,0, 6'h20,0,0,0,  1,6'h20,32'h1000_0020,0);
        av(1,1,6'h20, 0,0,0, 6'h21,0,0,0,  0,6'h20,32'h1000_0020,0);
        av(0,0,0,     0,0,0, 6'h20,0,0,0,  1,6'h20,32'h1000_0020,0);
        // Wrap: redirect to 62, run through 63 -> 0 -> 1
        av(0,1,6'd62, 0,0,0, 6'h21,0,0,0, 0,6'h20,32'h1000_0020,0);
        av(0,0,0, 0,0,0, 6'd62,0,0,0, 1,6'd62,32'h1000_003E,0);
        av(0,0,0, 0,0,0, 6'd63,0,0,0, 1,6'd63,32'h1000_003F,0);
        av(0,0,0, 0,0,0, 6'd0, 0,0,0, 1,6'd0, 32'h1000_0000,0);
        av(0,0,0, 0,0,0, 6'd1, 0,0,0, 1,6'd1, 32'h1000_0001,0);
        // Redirect to 10, then a three-word load session
        av(0,1,6'd10, 0,0,0, 6'd2,0,0,0, 0,6'd1,32'h1000_0001,0);
        av(0,0,0, 1,6'd0,32'hA, 6'd10,0,0,0, 0,6'd1,32'h1000_0001,0);
        av(0,0,0, 1,6'd0,32'hA, 6'd0,1,1,1,  0,6'd1,32'h1000_0001,1);
        av(1,0,0, 1,6'd1,32'hB, 6'd1,1,1,1,  0,6'd1,32'h1000_0001,2);
        av(0,1,6'd9, 1,6'd2,32'hC, 6'd2,1,1,1, 0,6'd1,32'h1000_0001,3);
        av(0,0,0, 0,6'd0,32'h0, 6'd0,0,0,1,  0,6'd1,32'h1000_0001,3);
        av(0,0,0, 1,6'd7,32'h7, 6'd10,0,0,1, 0,6'd1,32'h1000_0001,3);
        av(0,0,0, 0,0,0, 6'd0,0,0,0, 1,6'd0,32'hA,3);
        av(0,0,0, 0,0,0, 6'd1,0,0,0, 1,6'd1,32'hB,3);
        av(0,0,0, 0,0,0, 6'd2,0,0,0, 1,6'd2,32'hC,3);
        av(0,0,0, 0,0,0, 6'd3,0,0,0, 1,6'd3,32'h1000_0003,3);

        // Reset values
        #3;
        chk("rst if_valid", 32'(if_valid), 0);
        chk("rst if_pc",    32'(if_pc),    0);
        chk("rst if_instr", if_instr,      0);
        chk("rst ld_count", 32'(ld_count), 0);
        chk("rst loading",  32'(loading),  0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst mem_we",   32'(mem_we),   0);
        #9 rst_n = 1'b1;   // t=12, away from any edge

        foreach (vq[i]) begin
            stall = vq[i].st; branch_taken = vq[i].br; branch_target = vq[i].tgt;
            ld_req = vq[i].lr; ld_addr = vq[i].la; ld_data = vq[i].ld;
            #1;
            chk($sformatf("v%0d mem_addr", i),  32'(mem_addr), 32'(vq[i].e_ma));
            chk($sformatf("v%0d mem_we", i),    32'(mem_we),   32'(vq[i].e_we));
            chk($sformatf("v%0d ld_ack", i),    32'(ld_ack),   32'(vq[i].e_ack));
            chk($sformatf("v%0d loading", i),   32'(loading),  32'(vq[i].e_lo));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,     vq[i].ld);
            tick();
            chk($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(vq[i].e_v));
            chk($sformatf("v%0d if_pc", i),    32'(if_pc),    32'(vq[i].e_pc));
            chk($sformatf("v%0d if_instr", i), if_instr,      vq[i].e_in);
            chk($sformatf("v%0d ld_count", i), 32'(ld_count), 32'(vq[i].e_cnt));
        end
        stall = 0; branch_taken = 0;

        // Reset during the second load write
        ld_req = 1; ld_addr = 6'd5; ld_data = 32'h55;
        tick();                                   // enter LOAD
        tick();                                   // first write
        chk("mid cnt1", 32'(ld_count), 1);
        ld_addr = 6'd6; ld_data = 32'h66;
        #1 chk("mid we before rst", 32'(mem_we), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid we async",   32'(mem_we),   0);
        chk("mid ack async",  32'(ld_ack),   0);
        chk("mid valid",      32'(if_valid), 0);
        chk("mid ld_count",   32'(ld_count), 0);
        chk("mid loading",    32'(loading),  0);
        ld_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid ram6 kept", ram[6], 32'h1000_0006);
        chk("mid ram5 written", ram[5], 32'h55);
        chk("post-rst pc0",    32'(if_pc),    0);
        chk("post-rst instr0", if_instr,      32'hA);
        chk("post-rst valid",  32'(if_valid), 1);
        tick();
        chk("post-rst pc1",    32'(if_pc),    1);
        chk("post-rst instr1", if_instr,      32'hB);

        // Long session to the same address: count saturates at 64
        ld_req = 1; ld_addr = 6'd40;
        tick();
        for (int i = 0; i < 66; i++) begin
            ld_data = 32'(i);
            #1 if (i == 65) chk("sat ack", 32'(ld_ack), 1);
            tick();
            if (i == 62) chk("sat cnt63", 32'(ld_count), 63);
            if (i == 63) chk("sat cnt64", 32'(ld_count), 64);
        end
        chk("sat hold64", 32'(ld_count), 64);
        ld_req = 0;
        tick();                                   // -> RESTART
        chk("sat restart loading", 32'(loading), 1);
        tick();                                   // -> RUN, pc=0
        chk("sat run valid0", 32'(if_valid), 0);
        tick();
        chk("sat ram40", ram[40], 32'd65);
        chk("sat pc0",    32'(if_pc),    0);
        chk("sat instr",  if_instr,      32'hA);
        chk("sat valid",  32'(if_valid), 1);
        chk("sat cnt kept", 32'(ld_count), 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
